// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared op codes and FSM state encoding for the stack controller
package stack_pkg;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_PEEK = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR      = 3'd1,
        S_RD_ADDR = 3'd2,
        S_RD_DATA = 3'd3,
        S_ERR     = 3'd4
    } state_t;

endpackage

// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - stack memory initiator: push/pop/peek requests, occupancy and error flags
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int REG_BITS = 32,
    parameter int DEPTH    = 64,
    parameter int SP_BITS  = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic [1:0]          op_code,
    input  logic [REG_BITS-1:0] op_data,
    output logic                rsp_valid,
    output logic [REG_BITS-1:0] rsp_data,
    output logic                rsp_err,
    output logic [REG_BITS-1:0] mem_sp,
    output logic                mem_we,
    output logic [REG_BITS-1:0] mem_wdata,
    input  logic [REG_BITS-1:0] mem_rdata,
    output logic                full,
    output logic                empty,
    output logic [SP_BITS:0]    count
);

    localparam int CW = SP_BITS + 1;

    state_t state;

    assign op_ready = (state == S_IDLE) && !reset;
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    // Read data is only meaningful in RD_DATA; every other response carries zero.
    assign rsp_data = (state == S_RD_DATA) ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            count     <= '0;
            mem_sp    <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (op_valid) begin
                        case (op_code)
                            OP_PUSH: begin
                                if (full) begin
                                    state     <= S_ERR;
                                    rsp_valid <= 1'b1;
                                    rsp_err   <= 1'b1;
                                end else begin
                                    mem_sp    <= REG_BITS'(count);
                                    mem_wdata <= op_data;
                                    mem_we    <= 1'b1;
                                    count     <= count + CW'(1);
                                    rsp_valid <= 1'b1;
                                    state     <= S_WR;
                                end
                            end
                            OP_POP, OP_PEEK: begin
                                if (empty) begin
                                    state     <= S_ERR;
                                    rsp_valid <= 1'b1;
                                    rsp_err   <= 1'b1;
                                end else begin
                                    mem_sp <= REG_BITS'(count - CW'(1));
                                    if (op_code == OP_POP) begin
                                        count <= count - CW'(1);
                                    end
                                    state <= S_RD_ADDR;
                                end
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end
                // Memory samples mem_sp at the end of this cycle; respond next cycle.
                S_RD_ADDR: begin
                    rsp_valid <= 1'b1;
                    state     <= S_RD_DATA;
                end
                S_WR, S_RD_DATA, S_ERR: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// tb/tb_stack_ctrl.sv - scoreboard bench for stack_ctrl with a registered-read memory model
module tb_stack_ctrl;

    localparam logic [1:0] NOP  = 2'b00;
    localparam logic [1:0] PUSH = 2'b01;
    localparam logic [1:0] POP  = 2'b10;
    localparam logic [1:0] PEEK = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [1:0]  op_code = 2'b00;
    logic [31:0] op_data = '0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [31:0] mem_sp;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        full;
    logic        empty;
    logic [6:0]  count;

    stack_ctrl #(.REG_BITS(32), .DEPTH(64), .SP_BITS(6)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_data(op_data), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .mem_sp(mem_sp), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .full(full), .empty(empty),
        .count(count)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:63];
    always @(posedge clk) begin
        if (mem_we) mem[mem_sp[5:0]] <= mem_wdata;
        mem_rdata <= mem[mem_sp[5:0]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model[$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_err", 64'(rsp_err), 64'(e.err));
                check("rsp_data", 64'(rsp_data), 64'(e.data));
                check("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
            end
        end
    end

    task automatic do_op(input logic [1:0] code, input logic [31:0] d, input bit hold);
        exp_t e;
        int   t;
        bit   we_exp;
        bit   sp_chk;
        int   sp_exp;
        @(negedge clk);
        t = 0;
        while (!op_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!op_ready) check("op_ready_timeout", 64'd0, 64'd1);
        we_exp = 0;
        sp_chk = 0;
        sp_exp = 0;
        e.err  = 1'b0;
        e.data = '0;
        e.lat  = 1;
        e.acc  = cyc;
        case (code)
            PUSH: begin
                if (model.size() == 64) e.err = 1'b1;
                else begin
                    model.push_back(d);
                    we_exp = 1;
                    sp_chk = 1;
                    sp_exp = model.size() - 1;
                end
            end
            POP: begin
                if (model.size() == 0) e.err = 1'b1;
                else begin
                    e.data = model.pop_back();
                    e.lat  = 2;
                    sp_chk = 1;
                    sp_exp = model.size();
                end
            end
            PEEK: begin
                if (model.size() == 0) e.err = 1'b1;
                else begin
                    e.data = model[$];
                    e.lat  = 2;
                    sp_chk = 1;
                    sp_exp = model.size() - 1;
                end
            end
            default: ;
        endcase
        if (code != NOP) sb.push_back(e);
        op_valid = 1'b1;
        op_code  = code;
        op_data  = d;
        @(posedge clk);
        @(negedge clk);
        if (!hold) op_valid = 1'b0;
        check("count", 64'(count), 64'(model.size()));
        check("full", 64'(full), 64'(model.size() == 64));
        check("empty", 64'(empty), 64'(model.size() == 0));
        check("mem_we", 64'(mem_we), 64'(we_exp));
        if (sp_chk) check("mem_sp", 64'(mem_sp), 64'(sp_exp));
        if (we_exp) check("mem_wdata", 64'(mem_wdata), 64'(d));
        @(negedge clk);
        op_valid = 1'b0;
        check("mem_we_pulse", 64'(mem_we), 64'd0);
        t = 0;
        while (sb.size() != 0 && t < 10) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (sb.size() != 0) begin
            check("rsp_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        check("count_after", 64'(count), 64'(model.size()));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_count", 64'(count), 64'd0);
        check("rst_mem_sp", 64'(mem_sp), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_op_ready", 64'(op_ready), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        reset = 1'b0;

        do_op(PUSH, 32'hA5A5_0001, 0);
        do_op(PUSH, 32'hA5A5_0002, 0);
        do_op(POP, 32'h0, 0);
        do_op(POP, 32'h0, 0);
        check("empty_after_pops", 64'(empty), 64'd1);

        do_op(PUSH, 32'h0000_1234, 0);
        do_op(PEEK, 32'h0, 0);
        do_op(POP, 32'h0, 0);

        for (int i = 0; i < 64; i++) do_op(PUSH, $urandom, 0);
        check("full_at_64", 64'(full), 64'd1);
        do_op(PUSH, 32'hDEAD_BEEF, 0);
        do_op(PEEK, 32'h0, 0);
        for (int i = 0; i < 64; i++) do_op(POP, 32'h0, 0);

        do_op(POP, 32'h0, 1);
        do_op(PEEK, 32'h0, 0);
        do_op(NOP, 32'h0, 0);

        do_op(PUSH, 32'h0BAD_F00D, 0);
        @(negedge clk);
        op_valid = 1'b1;
        op_code  = POP;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        reset    = 1'b1;
        model.delete();
        check("rd_addr_op_ready", 64'(op_ready), 64'd0);
        @(negedge clk);
        check("abort_mem_we", 64'(mem_we), 64'd0);
        check("abort_count", 64'(count), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("release_op_ready", 64'(op_ready), 64'd1);
        check("release_empty", 64'(empty), 64'd1);
        repeat (4) @(negedge clk);
        check("abort_no_rsp", 64'(sb.size()), 64'd0);

        do_op(PUSH, 32'h5555_AAAA, 0);
        do_op(POP, 32'h0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
